// File: rtl/spi_slave_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave_responder_pkg
//  Description : Shared types and constants for the SPI mode-0 slave responder
//  Revision    : 1.0  initial release
// ============================================================================
package spi_slave_responder_pkg;

  // Frame-level state of the responder
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  // Only SPI mode 0 is supported: SCLK idles low, data sampled on the rising edge
  localparam int SPI_CPOL = 0;
  localparam int SPI_CPHA = 0;

  // Bit counter must hold 0..WIDTH-1 with one bit of headroom
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave_responder_if
//  Description : SPI pins plus the parallel word side of the slave responder
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_slave_responder_if #(
  parameter int WIDTH = 16
);
  import spi_slave_responder_pkg::*;

  logic             sclk;
  logic             ncs;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] txData;
  logic [WIDTH-1:0] rxData;
  logic             rxValid;
  logic             frameErr;
  logic             busy;

  // External SPI master plus the word producer/consumer
  modport master (
    output sclk, ncs, mosi, txData,
    input  miso, rxData, rxValid, frameErr, busy
  );

  // The responder itself
  modport slave (
    input  sclk, ncs, mosi, txData,
    output miso, rxData, rxValid, frameErr, busy
  );

endinterface
`default_nettype wire

// File: rtl/spi_slave_responder_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-flop synchroniser with history flop and registered
//                rise/fall pulses for one asynchronous input
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_level,
  output logic      o_rise,
  output logic      o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              r_rise;
  logic              r_fall;

  // Resynchronise the pin and register edge pulses so every consumer sees
  // a clean single-cycle strobe a fixed number of clocks after the pin moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{INIT}};
      r_hist <= INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_hist <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_hist;
      r_fall <= ~r_sync[STAGES-1] & r_hist;
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave_responder
//  Description : SPI mode-0 slave; oversamples SCLK/nCS/MOSI in the clk domain,
//                deserialises MSB-first words and shifts txData out on MISO
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_responder
  import spi_slave_responder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input wire logic           clk,
  input wire logic           reset,
  spi_slave_responder_if.slave bus
);

  localparam int              CW      = cnt_width(WIDTH);
  localparam logic [0:0]      c_IDLE  = IDLE;
  localparam logic [0:0]      c_SHIFT = SHIFT;
  localparam logic [CW-1:0]   c_LAST  = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_miso;
  logic             r_reload;

  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_ncs_rise;
  logic             w_ncs_fall;
  logic             w_mosi;
  logic             w_sclk_level_unused;
  logic             w_ncs_level_unused;
  logic             w_mosi_rise_unused;
  logic             w_mosi_fall_unused;
  logic [WIDTH-1:0] w_rx_next;

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst     (reset),
    .i_d     (bus.sclk),
    .o_level (w_sclk_level_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // nCS idles high, so its synchroniser resets high to avoid a false frame start
  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_ncs (
    .clk     (clk),
    .rst     (reset),
    .i_d     (bus.ncs),
    .o_level (w_ncs_level_unused),
    .o_rise  (w_ncs_rise),
    .o_fall  (w_ncs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst     (reset),
    .i_d     (bus.mosi),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  assign w_rx_next = {r_rx_shift[WIDTH-2:0], w_mosi};

  // Frame control, receive deserialiser and transmit serialiser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_miso      <= 1'b0;
      r_reload    <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_ncs_fall) begin
            r_state    <= c_SHIFT;
            r_tx_shift <= bus.txData;
            r_miso     <= bus.txData[WIDTH-1];
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_reload   <= 1'b0;
          end
        end
        c_SHIFT: begin
          // nCS release has priority over a coincident SCLK edge
          if (w_ncs_rise) begin
            r_state     <= c_IDLE;
            r_frame_err <= (r_bit_cnt != '0);
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_miso      <= 1'b0;
            r_reload    <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt == c_LAST) begin
              // Word boundary: publish and preload the next tx word for a burst
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
              r_tx_shift <= bus.txData;
              r_reload   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end else if (w_sclk_fall) begin
            if (r_reload) begin
              // First fall of a reloaded word presents its MSB without shifting
              r_miso   <= r_tx_shift[WIDTH-1];
              r_reload <= 1'b0;
            end else begin
              r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
              r_miso     <= r_tx_shift[WIDTH-2];
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.miso     = r_miso;
  assign bus.rxData   = r_rx_data;
  assign bus.rxValid  = r_rx_valid;
  assign bus.frameErr = r_frame_err;
  assign bus.busy     = (r_state == c_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_responder
//  Description : Directed bench for the SPI slave responder; a scoreboard
//                queue holds expected rxValid/frameErr events
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave_responder;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;
  localparam int HALF  = 10;   // sclk half period in clk cycles (5 MHz at 100 MHz)

  typedef struct {
    bit          is_err;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  mon_ev;

  always #5 clk = ~clk;

  spi_slave_responder_if #(.WIDTH(WIDTH)) bus ();

  spi_slave_responder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (!reset && bus.rxValid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rxValid: unexpected strobe, rxData %h", bus.rxData);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.is_err || bus.rxData !== mon_ev.data) begin
          errors++;
          $display("FAIL rxValid: got rxData %h, expected is_err=%0d data %h",
                   bus.rxData, mon_ev.is_err, mon_ev.data);
        end
      end
    end
    if (!reset && bus.frameErr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frameErr: unexpected strobe");
      end else begin
        mon_ev = exp_q.pop_front();
        if (!mon_ev.is_err) begin
          errors++;
          $display("FAIL frameErr: got frameErr, expected rxValid with data %h", mon_ev.data);
        end
      end
    end
  end

  task automatic frame_start();
    bus.ncs = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic frame_end();
    wait_cyc(HALF);
    bus.ncs = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  // Clock out n bits of w MSB first; capture miso at each rise.
  // txData switches to tx_mid before the 9th rise; with measure set, the clk
  // edges from the 16th rise to rxValid are counted.
  task automatic spi_bits(input logic [15:0] w, input int n, input logic [15:0] tx_mid,
                          input bit measure, output logic [15:0] got, output int lat);
    got = '0;
    lat = -1;
    for (int i = 0; i < n; i++) begin
      bus.mosi = w[15-i];
      if (i == 8) bus.txData = tx_mid;
      wait_cyc(HALF);
      bus.sclk = 1'b1;
      got[15-i] = bus.miso;
      if (measure && i == 15) begin
        for (int k = 1; k <= HALF; k++) begin
          @(posedge clk);
          #1;
          if (bus.rxValid && lat < 0) lat = k;
        end
      end else begin
        wait_cyc(HALF);
      end
      bus.sclk = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] got;
    logic [15:0] got2;
    int          lat;
    int          miso_bad;

    reset      = 1'b1;
    bus.sclk   = 1'b0;
    bus.ncs    = 1'b1;
    bus.mosi   = 1'b0;
    bus.txData = '0;
    wait_cyc(3);
    check("reset_miso",     32'(bus.miso),     32'd0);
    check("reset_rxData",   32'(bus.rxData),   32'd0);
    check("reset_rxValid",  32'(bus.rxValid),  32'd0);
    check("reset_frameErr", 32'(bus.frameErr), 32'd0);
    check("reset_busy",     32'(bus.busy),     32'd0);
    reset = 1'b0;
    wait_cyc(5);

    // Single word with latency measurement on the last rise
    bus.txData = 16'h3C5A;
    exp_q.push_back('{is_err: 1'b0, data: 16'hA5C3});
    frame_start();
    check("t1_busy_hi", 32'(bus.busy), 32'd1);
    spi_bits(16'hA5C3, 16, 16'h3C5A, 1'b1, got, lat);
    check("t1_miso_word", 32'(got), 32'h3C5A);
    check("t6_latency", 32'(lat), 32'(SYNC + 2));
    frame_end();
    check("t1_busy_lo", 32'(bus.busy), 32'd0);
    check("t1_rxData", 32'(bus.rxData), 32'hA5C3);

    // Burst of two words; second tx word comes from the updated txData
    bus.txData = 16'h1111;
    exp_q.push_back('{is_err: 1'b0, data: 16'h0001});
    exp_q.push_back('{is_err: 1'b0, data: 16'hFFFF});
    frame_start();
    spi_bits(16'h0001, 16, 16'h8000, 1'b0, got, lat);
    spi_bits(16'hFFFF, 16, 16'h8000, 1'b0, got2, lat);
    check("t2_miso_word1", 32'(got),  32'h1111);
    check("t2_miso_word2", 32'(got2), 32'h8000);
    frame_end();
    check("t2_rxData", 32'(bus.rxData), 32'hFFFF);

    // Abort after 7 rises
    exp_q.push_back('{is_err: 1'b1, data: 16'h0000});
    frame_start();
    spi_bits(16'hFE00, 7, 16'h8000, 1'b0, got, lat);
    frame_end();
    check("t3_rxData_kept", 32'(bus.rxData), 32'hFFFF);
    check("t3_busy_lo", 32'(bus.busy), 32'd0);

    // Reset in the middle of a frame, then a clean frame
    bus.txData = 16'hFFFF;
    frame_start();
    spi_bits(16'h5555, 9, 16'hFFFF, 1'b0, got, lat);
    check("t4_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t4_rst_miso",     32'(bus.miso),     32'd0);
    check("t4_rst_rxData",   32'(bus.rxData),   32'd0);
    check("t4_rst_rxValid",  32'(bus.rxValid),  32'd0);
    check("t4_rst_frameErr", 32'(bus.frameErr), 32'd0);
    check("t4_rst_busy",     32'(bus.busy),     32'd0);
    bus.ncs  = 1'b1;
    bus.sclk = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);
    bus.txData = 16'hABCD;
    exp_q.push_back('{is_err: 1'b0, data: 16'h1234});
    frame_start();
    spi_bits(16'h1234, 16, 16'hABCD, 1'b0, got, lat);
    check("t4_miso_word", 32'(got), 32'hABCD);
    frame_end();
    check("t4_rxData", 32'(bus.rxData), 32'h1234);

    // SCLK noise with nCS high
    miso_bad = 0;
    for (int p = 0; p < 20; p++) begin
      bus.mosi = 1'($urandom_range(0, 1));
      bus.sclk = 1'b1;
      for (int c = 0; c < 5; c++) begin
        wait_cyc(1);
        if (bus.miso !== 1'b0 || bus.busy !== 1'b0) miso_bad++;
      end
      bus.sclk = 1'b0;
      for (int c = 0; c < 5; c++) begin
        wait_cyc(1);
        if (bus.miso !== 1'b0 || bus.busy !== 1'b0) miso_bad++;
      end
    end
    wait_cyc(10);
    check("t5_miso_busy_quiet", 32'(miso_bad), 32'd0);
    check("t5_rxData_kept", 32'(bus.rxData), 32'h1234);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
